// File: rtl/cordic_request_queue_pkg.sv
// Shared definitions for the CORDIC request queue and the CORDIC control FSM.
package cordic_request_queue_pkg;

    // Sequencer states; the numeric values are also visible to the CORDIC FSM side.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACK  = 3'd2,
        GAP  = 3'd3,
        ERR  = 3'd4
    } state_e;

    // Quiet cycles after each ACK so the CORDIC FSM returns to idle before the next start.
    localparam int GAP_CYC = 2;

    // Operation encoding shared with the CORDIC FSM.
    localparam logic COS = 1'b0;
    localparam logic SIN = 1'b1;

endpackage

// File: rtl/cordic_request_queue_fifo.sv
// Small synchronous request FIFO with occupancy count and async active-low reset.
module cordic_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values advance by one on an effective push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cordic_request_queue.sv
// Command sequencer in front of the CORDIC control FSM: queues requests,
// issues them one at a time, captures results and watches for a hung CORDIC.
module cordic_request_queue
    import cordic_request_queue_pkg::*;
#(
    parameter int W           = 32,
    parameter int DEPTH       = 4,
    parameter int TAGW        = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [W-1:0]            req_angle,
    input  logic                    req_op,
    output logic                    beg_FSM_CORDIC,
    output logic                    operation,
    output logic [W-1:0]            angle_out,
    output logic                    ACK_FSM_CORDIC,
    input  logic                    ready_CORDIC,
    input  logic [W-1:0]            cordic_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [W-1:0]            res_data,
    output logic                    res_op,
    output logic [TAGW-1:0]         res_tag,
    output logic                    timeout_err,
    input  logic                    clr_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int EW = 1 + W + TAGW;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            beg_q, beg_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            err_pop_q, err_pop_d;
    logic            res_valid_q, res_valid_d;
    logic            res_op_q, res_op_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic [TAGW-1:0] res_tag_q, res_tag_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]   fifo_din, fifo_dout;
    logic            head_op;
    logic [W-1:0]    head_angle;
    logic [TAGW-1:0] head_tag;
    logic            capture;

    // A full FIFO refuses pushes even when the head is being popped that cycle.
    assign fifo_push = req_valid && !fifo_full;
    assign fifo_pop  = (state_q == ACK) || err_pop_q;
    assign fifo_din  = {req_op, req_angle, tag_q};
    assign {head_op, head_angle, head_tag} = fifo_dout;
    assign capture   = (state_q == WAIT) && ready_CORDIC && (!res_valid_q || res_ready);

    cordic_req_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign req_ready      = !fifo_full;
    assign beg_FSM_CORDIC = beg_q;
    assign ACK_FSM_CORDIC = ack_q;
    assign operation      = fifo_empty ? COS : head_op;
    assign angle_out      = fifo_empty ? '0 : head_angle;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_op         = res_op_q;
    assign res_tag        = res_tag_q;
    assign timeout_err    = err_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;

    // Next-state, watchdog, tag and result-register logic; capture beats timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        beg_d       = 1'b0;
        ack_d       = 1'b0;
        err_d       = err_q;
        err_pop_d   = 1'b0;
        tag_d       = tag_q + TAGW'(fifo_push);
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_tag_d   = res_tag_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty && !err_q) begin
                    state_d = WAIT;
                    beg_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (capture) begin
                    res_valid_d = 1'b1;
                    res_data_d  = cordic_result;
                    res_op_d    = head_op;
                    res_tag_d   = head_tag;
                    ack_d       = 1'b1;
                    state_d     = ACK;
                end else if (cnt_q == CNT_MAX) begin
                    err_d     = 1'b1;
                    err_pop_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    beg_d = 1'b1;
                end
            end
            ACK: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ERR: begin
                if (clr_err) begin
                    err_d   = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All sequencer state, including registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            tag_q       <= '0;
            beg_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_pop_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            tag_q       <= tag_d;
            beg_q       <= beg_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_pop_q   <= err_pop_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_tag_q   <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_cordic_request_queue.sv
// Randomized scoreboard bench for the CORDIC request queue, with directed
// scenarios for latency, burst, backpressure, timeout, reset and tag wrap.
module tb_cordic_request_queue;
    localparam int W           = 32;
    localparam int DEPTH       = 4;
    localparam int TAGW        = 4;
    localparam int TIMEOUT_CYC = 1023;
    localparam int LW          = $clog2(DEPTH) + 1;

    typedef struct { logic op; logic [W-1:0] angle; logic [TAGW-1:0] tag; } req_t;
    typedef struct { logic [W-1:0] data; logic op; logic [TAGW-1:0] tag; } res_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready, req_op;
    logic [W-1:0]    req_angle;
    logic            beg_FSM_CORDIC, operation, ACK_FSM_CORDIC;
    logic [W-1:0]    angle_out;
    logic            ready_CORDIC;
    logic [W-1:0]    cordic_result;
    logic            res_valid, res_ready, res_op;
    logic [W-1:0]    res_data;
    logic [TAGW-1:0] res_tag;
    logic            timeout_err, clr_err, busy;
    logic [LW-1:0]   level;

    int   errors = 0;
    int   checks = 0;
    int   tagCount = 0;
    int   ackCount = 0;
    int   consumeMode = 0;
    logic [W-1:0] lastResult;
    req_t mq[$];
    res_t expQ[$];

    cordic_request_queue #(
        .W(W), .DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle), .req_op(req_op),
        .beg_FSM_CORDIC(beg_FSM_CORDIC), .operation(operation), .angle_out(angle_out),
        .ACK_FSM_CORDIC(ACK_FSM_CORDIC), .ready_CORDIC(ready_CORDIC), .cordic_result(cordic_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
        .res_tag(res_tag), .timeout_err(timeout_err), .clr_err(clr_err), .busy(busy), .level(level)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name, input string detail);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Offer one request; recorded in the model queue once req_ready is seen high.
    task automatic applyStimulus(input logic op, input logic [W-1:0] angle);
        int   cyc = 0;
        req_t r;
        req_valid = 1'b1;
        req_op    = op;
        req_angle = angle;
        while (!req_ready && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            failNote("request accept", "req_ready never rose");
        end else begin
            r.op    = op;
            r.angle = angle;
            r.tag   = TAGW'(tagCount % (1 << TAGW));
            mq.push_back(r);
            tagCount++;
        end
        @(negedge clk);
    endtask

    // Behaves as the CORDIC FSM for n requests: answers each start after a random delay.
    task automatic serveCordic(input int n, input int minDly, input int maxDly);
        for (int i = 0; i < n; i++) begin
            int   cyc = 0;
            int   gap = 0;
            int   dly;
            res_t e;
            while (!beg_FSM_CORDIC && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            if (!beg_FSM_CORDIC) begin
                failNote("beg wait", "start never issued");
                return;
            end
            if (mq.size() == 0) begin
                failNote("beg with empty model", "start issued with no queued request");
                return;
            end
            checkOutput("operation", operation, mq[0].op);
            checkOutput("angle_out", angle_out, mq[0].angle);
            dly = $urandom_range(maxDly, minDly);
            repeat (dly) @(negedge clk);
            checkOutput("beg held", beg_FSM_CORDIC, 1);
            checkOutput("angle stable", angle_out, mq[0].angle);
            lastResult    = $urandom;
            cordic_result = lastResult;
            ready_CORDIC  = 1'b1;
            e.data = lastResult;
            e.op   = mq[0].op;
            e.tag  = mq[0].tag;
            expQ.push_back(e);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ACK_FSM_CORDIC && cyc < 3000);
            ready_CORDIC = 1'b0;
            if (!ACK_FSM_CORDIC) begin
                failNote("ACK wait", "acknowledge never issued");
                return;
            end
            ackCount++;
            checkOutput("beg low in ACK", beg_FSM_CORDIC, 0);
            checkOutput("res_data at ACK", res_data, e.data);
            checkOutput("res_tag at ACK", res_tag, e.tag);
            void'(mq.pop_front());
            if (mq.size() > 0) begin
                do begin
                    @(negedge clk);
                    gap++;
                    if (gap == 1) checkOutput("ACK single pulse", ACK_FSM_CORDIC, 0);
                end while (!beg_FSM_CORDIC && gap < 10);
                checkOutput("ACK-to-beg spacing", gap, 4);
            end
        end
    endtask

    task automatic drainResults();
        int cyc = 0;
        consumeMode = 0;
        while (expQ.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("scoreboard drained", expQ.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic clearModel();
        mq.delete();
        expQ.delete();
        tagCount = 0;
    endtask

    // Consumer: random res_ready in mode 0; other modes leave it to the main sequence.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (consumeMode == 0) res_ready = ($urandom_range(3, 0) != 0);
        end
    end

    // Scoreboard monitor: each result handshake is matched against the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && res_valid && res_ready) begin
                if (expQ.size() == 0) begin
                    failNote("unexpected result", $sformatf("res_data=0x%0h with nothing expected", res_data));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("scoreboard res_data", res_data, e.data);
                    checkOutput("scoreboard res_op", res_op, e.op);
                    checkOutput("scoreboard res_tag", res_tag, e.tag);
                end
            end
        end
    end

    // Global time limit so a stuck run still terminates.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] time limit");
    end

    // Main sequence of directed and random scenarios.
    initial begin
        int n;
        logic [W-1:0] resA, resB;
        res_t e;
        reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_angle = '0;
        ready_CORDIC = 1'b0; cordic_result = '0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset beg", beg_FSM_CORDIC, 0);
        checkOutput("reset ACK", ACK_FSM_CORDIC, 0);
        checkOutput("reset res_valid", res_valid, 0);
        checkOutput("reset res_data", res_data, 0);
        checkOutput("reset timeout_err", timeout_err, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset level", level, 0);
        checkOutput("reset angle_out", angle_out, 0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] single request latency");
        consumeMode = 1; res_ready = 1'b1;
        checkOutput("single req_ready", req_ready, 1);
        applyStimulus(1'b1, 32'h3F490FDB);
        req_valid = 1'b0;
        checkOutput("single beg at cycle 1", beg_FSM_CORDIC, 0);
        checkOutput("single level", level, 1);
        checkOutput("single busy", busy, 1);
        @(negedge clk);
        checkOutput("single beg at cycle 2", beg_FSM_CORDIC, 1);
        checkOutput("single operation", operation, 1);
        checkOutput("single angle_out", angle_out, 32'h3F490FDB);
        ready_CORDIC = 1'b1; cordic_result = 32'h3F3504F3;
        e.data = 32'h3F3504F3; e.op = 1'b1; e.tag = '0;
        expQ.push_back(e);
        @(negedge clk);
        ready_CORDIC = 1'b0;
        void'(mq.pop_front());
        checkOutput("single ACK", ACK_FSM_CORDIC, 1);
        checkOutput("single beg in ACK", beg_FSM_CORDIC, 0);
        checkOutput("single res_valid", res_valid, 1);
        checkOutput("single res_data", res_data, 32'h3F3504F3);
        checkOutput("single res_op", res_op, 1);
        checkOutput("single res_tag", res_tag, 0);
        @(negedge clk);
        checkOutput("single ACK gap1", ACK_FSM_CORDIC, 0);
        checkOutput("single beg gap1", beg_FSM_CORDIC, 0);
        checkOutput("single busy gap1", busy, 1);
        @(negedge clk);
        checkOutput("single beg gap2", beg_FSM_CORDIC, 0);
        checkOutput("single level after pop", level, 0);
        @(negedge clk);
        checkOutput("single idle busy", busy, 0);
        drainResults();

        $display("[TB] burst into full FIFO");
        ackCount = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus($urandom_range(1, 0), $urandom);
                checkOutput("burst req_ready full", req_ready, 0);
                checkOutput("burst level full", level, 4);
                applyStimulus($urandom_range(1, 0), $urandom);
                checkOutput("burst 5th after first pop", ackCount, 1);
                req_valid = 1'b0;
            end
            serveCordic(5, 4, 6);
        join
        drainResults();

        $display("[TB] result backpressure");
        consumeMode = 1; res_ready = 1'b0;
        applyStimulus(1'b0, $urandom);
        applyStimulus(1'b1, $urandom);
        req_valid = 1'b0;
        serveCordic(1, 0, 0);
        resA = lastResult;
        resB = $urandom;
        ready_CORDIC = 1'b1; cordic_result = resB;
        e.data = resB; e.op = mq[0].op; e.tag = mq[0].tag;
        expQ.push_back(e);
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp ACK withheld", ACK_FSM_CORDIC, 0);
            checkOutput("bp beg held", beg_FSM_CORDIC, 1);
            checkOutput("bp first result kept", res_data, resA);
        end
        res_ready = 1'b1;
        @(negedge clk);
        ready_CORDIC = 1'b0;
        void'(mq.pop_front());
        checkOutput("bp ACK after free", ACK_FSM_CORDIC, 1);
        checkOutput("bp res_valid", res_valid, 1);
        checkOutput("bp second result", res_data, resB);
        @(negedge clk);
        checkOutput("bp ACK one cycle", ACK_FSM_CORDIC, 0);
        drainResults();

        $display("[TB] watchdog timeout");
        applyStimulus(1'b0, 32'h11111111);
        applyStimulus(1'b1, 32'h22222222);
        req_valid = 1'b0;
        n = 0;
        while (!beg_FSM_CORDIC && n < 20) begin @(negedge clk); n++; end
        checkOutput("to beg issued", beg_FSM_CORDIC, 1);
        n = 0;
        while (!timeout_err && n < 1200) begin @(negedge clk); n++; end
        checkOutput("to cycles in range", (n >= TIMEOUT_CYC) && (n <= TIMEOUT_CYC + 1), 1);
        if (!timeout_err) $display("[TB] timeout_err still low after %0d cycles", n);
        checkOutput("to beg dropped", beg_FSM_CORDIC, 0);
        @(negedge clk);
        void'(mq.pop_front());
        checkOutput("to level after discard", level, 1);
        repeat (5) @(negedge clk);
        checkOutput("to err sticky", timeout_err, 1);
        checkOutput("to beg stays low", beg_FSM_CORDIC, 0);
        checkOutput("to single discard", level, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("to err cleared", timeout_err, 0);
        serveCordic(1, 0, 2);
        drainResults();

        $display("[TB] reset during WAIT");
        consumeMode = 1; res_ready = 1'b0;
        applyStimulus(1'b0, $urandom);
        applyStimulus(1'b1, $urandom);
        req_valid = 1'b0;
        serveCordic(1, 0, 0);
        checkOutput("rst pre beg", beg_FSM_CORDIC, 1);
        reset = 1'b0;
        #1;
        checkOutput("rst beg", beg_FSM_CORDIC, 0);
        checkOutput("rst ACK", ACK_FSM_CORDIC, 0);
        checkOutput("rst res_valid", res_valid, 0);
        checkOutput("rst level", level, 0);
        checkOutput("rst req_ready", req_ready, 1);
        clearModel();
        @(negedge clk);
        reset = 1'b1;
        consumeMode = 0;
        applyStimulus(1'b1, $urandom);
        req_valid = 1'b0;
        serveCordic(1, 0, 2);
        drainResults();

        $display("[TB] tag wrap");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clearModel();
        for (int i = 0; i < 17; i++) begin
            applyStimulus($urandom_range(1, 0), $urandom);
            req_valid = 1'b0;
            serveCordic(1, 0, 1);
        end
        checkOutput("wrap 17th tag", res_tag, 0);
        drainResults();

        $display("[TB] random traffic");
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    applyStimulus($urandom_range(1, 0), $urandom);
                    req_valid = 1'b0;
                end
            end
            serveCordic(30, 0, 4);
        join
        drainResults();
        checkOutput("final level", level, 0);
        checkOutput("final busy", busy, 0);
        checkOutput("final model empty", mq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_request_queue.md
Name: cordic_request_queue

Overview:
- Front-end command sequencer sitting directly upstream of the CORDIC control FSM.
- Accepts sine/cosine requests over a valid/ready interface and buffers them in a small FIFO.
- Drives the CORDIC start/ack handshake one request at a time, holding operands stable until the result is ready.
- Captures each result into a single output register with valid/ready backpressure; a watchdog flags a hung CORDIC.

Parameters:
- W, 32: angle/result width.
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- TAGW, 4: sequence tag width.
- TIMEOUT_CYC, 1023: maximum cycles in WAIT before error; at least 64.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when both high
req_angle  in  W  input angle
req_op  in  1  0=cosine, 1=sine
beg_FSM_CORDIC  out  1  start to CORDIC FSM
operation  out  1  head-of-queue op
angle_out  out  W  head-of-queue angle
ACK_FSM_CORDIC  out  1  one-cycle result acknowledge
ready_CORDIC  in  1  CORDIC result valid; held until ACK
cordic_result  in  W  CORDIC output
res_valid  out  1  result register full
res_ready  in  1  consumer takes result
res_data  out  W  captured result
res_op  out  1  op of captured result
res_tag  out  TAGW  tag of captured result
timeout_err  out  1  sticky watchdog error
clr_err  in  1  clears error, resumes
busy  out  1  state != IDLE or FIFO not empty
level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty, tag counter 0, state IDLE. All outputs are 0, except req_ready, which is 1.
- Reset mid-operation abandons the in-flight request. The CORDIC FSM is reset from the same source.
- FIFO entry is {op, angle, tag}.
  - req_ready = !full. Enqueue on req_valid&&req_ready and stamp the current tag; the tag counter then increments, wrapping at 2^TAGW.
  - A full FIFO accepts nothing, even in a pop cycle.
  - Head is popped only in ACK or ERR.
- operation/angle_out are driven from the FIFO head. They stay stable from WAIT entry until the pop.
- States:
  - IDLE: if !empty and !timeout_err -> WAIT; clear the cycle counter.
  - WAIT: beg_FSM_CORDIC=1. The counter increments each cycle.
    - If ready_CORDIC && (!res_valid || res_ready): load res_data=cordic_result, res_op, res_tag from the head; res_valid=1; -> ACK.
    - If ready_CORDIC but the output register stays full: hold in WAIT. The counter still runs.
    - If counter==TIMEOUT_CYC: timeout_err=1 -> ERR.
  - ACK: ACK_FSM_CORDIC=1 for exactly one cycle, beg=0; pop head; -> GAP.
  - GAP: beg=0 for exactly 2 cycles, so the CORDIC FSM passes its reset/idle state before the next start; -> IDLE.
  - ERR: beg=0; pop the offending head once on entry. Remain until clr_err=1, which clears timeout_err -> GAP.
- Output register:
  - res_valid clears on res_ready when no new capture happens that cycle.
  - A capture and a consume in the same cycle leave res_valid=1 with the new data.
- Latency: a request into an empty idle block at cycle 0 produces beg high at cycle 2. A result is visible at res_valid one cycle after ready_CORDIC is sampled with the slot free.
- Minimum request-to-request spacing at the CORDIC is WAIT + ACK + 2 GAP + IDLE cycles.
- The counter saturates. Simultaneous timeout and ready_CORDIC gives priority to the capture.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE/WAIT/ACK/GAP/ERR;
  - GAP_CYC=2;
  - the op encoding constants (COS=0, SIN=1), shared with the CORDIC FSM.
- One sub-module: cordic_req_fifo, a synchronous FIFO with push/pop/full/empty/level and the same async active-low reset.

Test Plan:
- Single request: angle=0x3F490FDB, op=1 enqueued. Required: beg high at cycle 2; after ready_CORDIC with result 0x3F3504F3, res_data=0x3F3504F3, res_op=1, res_tag=0, one ACK pulse, then 2 GAP cycles.
- Burst: 5 back-to-back requests into DEPTH=4. Required: req_ready low after the 4th; the 5th is accepted after the first ACK pop; res_tag sequence is 0,1,2,3,4.
- Backpressure: hold res_ready=0 while a second result is ready. Required: block stays in WAIT and ACK is withheld; ACK pulses the cycle after res_ready=1 frees the slot, and the first result is not overwritten.
- Timeout: ready_CORDIC never rises. Required: timeout_err=1 after TIMEOUT_CYC cycles, beg drops, the head is discarded, level decrements by 1; clr_err resumes with the next entry.
- Reset mid-WAIT: reset low for 1 cycle. Required: immediately beg=0, ACK=0, res_valid=0, level=0, req_ready=1; after release the tag restarts at 0.
- Tag wrap: 17 sequential requests with TAGW=4. Required: the 17th result carries res_tag=0.
